// File: rtl/ppi_peer_pkg.sv
// ppi_peer_pkg: shared types and defaults for the 8255 handshake peer.
// FSM state enums, arbiter grant encoding, pulse/timeout defaults.
package ppi_peer_pkg;

  localparam int ACK_CYCLES_DEF  = 4;
  localparam int STB_CYCLES_DEF  = 4;
  localparam int IBF_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ACK,
    R_WAIT
  } rx_state_e;

  typedef enum logic [2:0] {
    T_IDLE,
    T_LOAD,
    T_STB,
    T_WAIT_HI,
    T_WAIT_LO
  } tx_state_e;

  typedef enum logic [1:0] {
    G_NONE,
    G_RX,
    G_TX
  } grant_e;

  function automatic int cnt_max(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/ppi_peer_fifo.sv
// ppi_peer_fifo: synchronous byte FIFO with registered occupancy count.
// Push when full and pop when empty are ignored.
module ppi_peer_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] wr_data,
  input  logic       pop,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointer, count and storage update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ppi_handshake_peer.sv
// ppi_handshake_peer: external-device partner on 8255 port A strobed modes.
// Define PPI_PEER_MODE2_EN to compile in the TX (mode 2) path.
module ppi_handshake_peer
  import ppi_peer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_CYCLES  = ACK_CYCLES_DEF,
  parameter int STB_CYCLES  = STB_CYCLES_DEF,
  parameter int IBF_TIMEOUT = IBF_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ppi_pa_out,
  input  logic       ppi_obf_n,
  input  logic       ppi_ibf,
  output logic [7:0] ppi_pa_in,
  output logic       ppi_ack_n,
  output logic       ppi_stb_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_nack
);

  localparam int CNT_MAX = cnt_max(ACK_CYCLES, STB_CYCLES, IBF_TIMEOUT);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_CYCLES - 1);

  rx_state_e     rx_state;
  rx_state_e     rx_state_nxt;
  grant_e        grant;
  logic [CW-1:0] cnt;
  logic          rx_elig;
  logic          rx_push;
  logic          rx_pop;
  logic          rx_full;
  logic          rx_empty;
  logic          tx_busy;
  logic          tx_elig;
  logic          tx_chg;

  assign rx_elig  = !ppi_obf_n && !rx_full;
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;

  ppi_peer_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (rx_push),
    .wr_data (ppi_pa_out),
    .pop     (rx_pop),
    .rd_data (rx_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  // One transaction at a time; RX wins a tie from idle.
  always_comb begin
    grant = G_NONE;
    if (rx_state != R_IDLE) grant = G_RX;
    else if (tx_busy)       grant = G_TX;
    else if (rx_elig)       grant = G_RX;
    else if (tx_elig)       grant = G_TX;
  end

  // RX next state: ACK pulse, capture on its last cycle, wait OBF release.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_push      = 1'b0;
    unique case (rx_state)
      R_IDLE: if (grant == G_RX) rx_state_nxt = R_ACK;
      R_ACK: begin
        if (cnt == ACK_LAST) begin
          rx_push      = 1'b1;
          rx_state_nxt = R_WAIT;
        end
      end
      R_WAIT:  if (ppi_obf_n) rx_state_nxt = R_IDLE;
      default: rx_state_nxt = R_IDLE;
    endcase
  end

  // RX state and registered ACK pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= R_IDLE;
      ppi_ack_n <= 1'b1;
    end else begin
      rx_state  <= rx_state_nxt;
      ppi_ack_n <= (rx_state_nxt != R_ACK);
    end
  end

  // Shared pulse/timeout counter, restarted on any state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if ((rx_state_nxt != rx_state) || tx_chg) cnt <= '0;
    else if (cnt != '1) cnt <= cnt + 1'b1;
  end

`ifdef PPI_PEER_MODE2_EN
  localparam logic [CW-1:0] STB_LAST = CW'(STB_CYCLES - 1);
  localparam logic [CW-1:0] IBF_LAST = CW'(IBF_TIMEOUT - 1);

  tx_state_e  tx_state;
  tx_state_e  tx_state_nxt;
  logic       tx_push;
  logic       tx_pop;
  logic       tx_full;
  logic       tx_empty;
  logic       nack_set;
  logic [7:0] tx_head;

  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign tx_elig  = (!tx_empty || tx_push) && !ppi_ibf;
  assign tx_busy  = (tx_state != T_IDLE);
  assign tx_chg   = (tx_state_nxt != tx_state);

  ppi_peer_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (tx_push),
    .wr_data (tx_data),
    .pop     (tx_pop),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  // TX next state: load, strobe, then follow IBF up and down.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_pop       = 1'b0;
    nack_set     = 1'b0;
    unique case (tx_state)
      T_IDLE: if (grant == G_TX) tx_state_nxt = T_LOAD;
      T_LOAD: begin
        tx_pop       = 1'b1;
        tx_state_nxt = T_STB;
      end
      T_STB: if (cnt == STB_LAST) tx_state_nxt = T_WAIT_HI;
      T_WAIT_HI: begin
        if (ppi_ibf) begin
          tx_state_nxt = T_WAIT_LO;
        end else if (cnt == IBF_LAST) begin
          nack_set     = 1'b1;
          tx_state_nxt = T_IDLE;
        end
      end
      T_WAIT_LO: if (!ppi_ibf) tx_state_nxt = T_IDLE;
      default:   tx_state_nxt = T_IDLE;
    endcase
  end

  // TX state, STB pin, port A input byte and sticky NACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= T_IDLE;
      ppi_stb_n <= 1'b1;
      ppi_pa_in <= 8'hFF;
      tx_nack   <= 1'b0;
    end else begin
      tx_state  <= tx_state_nxt;
      ppi_stb_n <= (tx_state_nxt != T_STB);
      if (tx_state == T_LOAD) ppi_pa_in <= tx_head;
      if (nack_set) tx_nack <= 1'b1;
    end
  end
`else
  logic unused_tx;

  assign unused_tx = ^{tx_data, tx_valid, ppi_ibf};
  assign tx_ready  = 1'b0;
  assign ppi_stb_n = 1'b1;
  assign ppi_pa_in = 8'hFF;
  assign tx_nack   = 1'b0;
  assign tx_busy   = 1'b0;
  assign tx_elig   = 1'b0;
  assign tx_chg    = 1'b0;
`endif

endmodule
